// File: rtl/fpu_issue_controller.sv
// fpu_issue_controller: issues one decoded op at a time to the
// fixed-point unit and returns it as a single writeback pulse.
module fpu_issue_controller #(
  parameter int WIDTH   = 32,
  parameter int FBITS   = 10,
  parameter int GUARD   = 2,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_err,
  output logic             busy
);

  localparam logic [1:0] FPU_ADD  = 2'd0;
  localparam logic [1:0] FPU_SUB  = 2'd1;
  localparam logic [1:0] FPU_MUL  = 2'd2;
  localparam logic [1:0] FPU_SQRT = 2'd3;

  localparam logic [5:0] GUARD_C = 6'(GUARD);
  localparam logic [5:0] TMO_C   = 6'(TIMEOUT);
  localparam logic [5:0] CNT_MAX = 6'h3f;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [5:0]       cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rs1_q;
  logic [WIDTH-1:0] rs2_q;
  logic [4:0]       rd_q;

  logic accept;
  logic is_long;
  logic done;
  logic tmo;
  logic finish;

  // Fractional width only describes the unit's number format.
  logic unused_fbits;
  assign unused_fbits = (FBITS < 0);

  assign accept  = (state_q == IDLE) && req_valid && !flush;
  assign is_long = (op_q == FPU_MUL) || (op_q == FPU_SQRT);

  // Long ops ignore ready for GUARD cycles to mask a stale ready.
  assign done = is_long ? ((cnt_q >= GUARD_C) && fpu_ready)
                        : (cnt_q == '0);
  assign tmo    = is_long && !done && (cnt_q == TMO_C);
  assign finish = (state_q == EXEC) && !flush && (done || tmo);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush) state_d = EXEC;
      end
      EXEC: begin
        if (flush)              state_d = IDLE;
        else if (done || tmo)   state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      op_q    <= FPU_ADD;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_err  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
        op_q  <= req_op;
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
        rd_q  <= req_rd;
      end else if (state_q == EXEC && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (finish) begin
        wb_rd   <= rd_q;
        wb_data <= done ? fpu_result : '0;
        wb_err  <= !done;
      end
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    busy          = 1'b1;
    wb_valid      = 1'b0;
    fpu_operation = FPU_ADD;
    fpu_operand_1 = '0;
    fpu_operand_2 = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      EXEC: begin
        fpu_operation = op_q;
        fpu_operand_1 = rs1_q;
        fpu_operand_2 = rs2_q;
      end
      WB:      wb_valid = !flush && reset;
      default: ;
    endcase
  end

  logic unused_sub;
  assign unused_sub = (FPU_SUB == FPU_ADD);

endmodule

// File: tb/tb_fpu_issue_controller.sv
// tb_fpu_issue_controller: directed and randomized ops against a
// transaction-level model of issue, completion and writeback.
module tb_fpu_issue_controller;

  localparam int W       = 32;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 63;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_rs1;
  logic [W-1:0] req_rs2;
  logic [4:0]   req_rd;
  logic         flush;
  logic [W-1:0] fpu_operand_1;
  logic [W-1:0] fpu_operand_2;
  logic [1:0]   fpu_operation;
  logic [W-1:0] fpu_result;
  logic         fpu_ready;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic         wb_err;
  logic         busy;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0] last_data;
  logic [4:0]   last_rd;
  logic         last_err;

  fpu_issue_controller #(
    .WIDTH(W), .FBITS(10), .GUARD(GUARD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .flush(flush),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
    .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] isqrt(input longint unsigned x);
    longint unsigned r;
    longint unsigned t;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[W-1:0];
  endfunction

  // Q(W-FBITS).10 behaviour of the fixed-point unit.
  function automatic logic [W-1:0] unit_model(input logic [1:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_MUL: begin
        p = {32'd0, a} * {32'd0, b};
        return p[W+9:10];
      end
      default: return isqrt({22'd0, a, 10'd0});
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    chk({tag, "_op"}, 32'(fpu_operation), 32'(OP_ADD));
    chk({tag, "_a"}, fpu_operand_1, '0);
    chk({tag, "_b"}, fpu_operand_2, '0);
  endtask

  // mode: 0 ready stuck low, 1 ready stuck high, 2 random ready.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
      input logic [W-1:0] b, input logic [4:0] rd, input int mode,
      input int flush_at, input bit flush_wb);
    logic [W-1:0] good;
    bit r;
    bit fin;
    bit tmo;
    int j;
    good = unit_model(op, a, b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    req_rd = rd; flush = 1'b0; fpu_ready = (mode == 1);
    fpu_result = $urandom;
    #1 chk("accept_ready", 32'(req_ready), 32'd1);
    j = 0; fin = 1'b0; tmo = 1'b0;
    while (!fin && !tmo) begin
      @(negedge clk);
      req_valid = 1'($urandom); req_op = 2'($urandom);
      req_rs1 = $urandom; req_rs2 = $urandom; req_rd = 5'($urandom);
      case (mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        default: r = ($urandom_range(0, 3) == 0);
      endcase
      fpu_ready = r;
      fin = (op == OP_ADD || op == OP_SUB) ? (j == 0) : (r && j >= GUARD);
      tmo = !fin && (j == TIMEOUT);
      fpu_result = fin ? good : $urandom;
      flush = (j == flush_at);
      #1;
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_ready", 32'(req_ready), 32'd0);
      chk("exec_wbv", 32'(wb_valid), 32'd0);
      chk("exec_op", 32'(fpu_operation), 32'(op));
      chk("exec_a", fpu_operand_1, a);
      chk("exec_b", fpu_operand_2, b);
      if (flush) begin
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; fpu_ready = 1'b0;
        #1;
        chk_idle("flush_exec");
        chk("flush_hold_data", wb_data, last_data);
        chk("flush_hold_rd", 32'(wb_rd), 32'(last_rd));
        return;
      end
      j++;
    end
    @(negedge clk);
    req_valid = 1'b0; fpu_ready = 1'($urandom);
    fpu_result = $urandom; flush = flush_wb;
    last_data = tmo ? '0 : good;
    last_err = tmo;
    last_rd = rd;
    #1;
    chk("wb_valid", 32'(wb_valid), 32'(!flush_wb));
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    chk("wb_data", wb_data, last_data);
    chk("wb_err", 32'(wb_err), 32'(last_err));
    chk("wb_busy", 32'(busy), 32'd1);
    chk("wb_ready", 32'(req_ready), 32'd0);
    chk("wb_op", 32'(fpu_operation), 32'(OP_ADD));
    chk("wb_a", fpu_operand_1, '0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk_idle("post_wb");
    chk("hold_data", wb_data, last_data);
    chk("hold_err", 32'(wb_err), 32'(last_err));
  endtask

  initial begin
    int acc[$];
    int wbc[$];
    logic [1:0]   rop;
    logic [W-1:0] ra;
    int           rmode;
    int           rflush;

    reset = 1'b0; req_valid = 1'b0; req_op = OP_ADD;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; flush = 1'b0;
    fpu_ready = 1'b0; fpu_result = '0;
    last_data = '0; last_rd = '0; last_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset_wb_rd", 32'(wb_rd), 32'd0);
    chk("reset_wb_data", wb_data, '0);
    chk("reset_wb_err", 32'(wb_err), 32'd0);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0;

    run_op(OP_ADD, 32'h600, 32'h800, 5'd5, 2, -1, 1'b0);
    chk("add_15_plus_20", wb_data, 32'hE00);
    run_op(OP_MUL, 32'h400, 32'h400, 5'd1, 1, -1, 1'b0);
    run_op(OP_MUL, 32'h600, 32'h800, 5'd2, 1, -1, 1'b0);
    chk("mul_stale_ready", wb_data, 32'hC00);
    run_op(OP_SQRT, 32'h1000, 32'h55, 5'd3, 2, -1, 1'b0);
    chk("sqrt_4", wb_data, 32'h800);
    run_op(OP_SUB, 32'h200, 32'h600, 5'd4, 0, -1, 1'b0);
    run_op(OP_MUL, 32'h600, 32'h800, 5'd6, 0, -1, 1'b0);
    chk("timeout_err", 32'(wb_err), 32'd1);
    run_op(OP_MUL, 32'h600, 32'h800, 5'd7, 0, 3, 1'b0);
    run_op(OP_ADD, 32'h123, 32'h456, 5'd8, 2, -1, 1'b1);

    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = OP_MUL;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1 chk_idle("flush_in_idle");

    for (int n = 0; n < 20; n++) begin
      rop = 2'($urandom);
      ra = (rop == OP_SQRT) ? 32'($urandom_range(0, 1 << 20)) : $urandom;
      rmode = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2));
      rflush = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_op(rop, ra, $urandom, 5'($urandom), rmode, rflush,
             ($urandom_range(0, 7) == 0));
    end

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = (c < 6); req_op = OP_ADD; flush = 1'b0;
      req_rs1 = (c < 3) ? 32'h100 : 32'h300;
      req_rs2 = (c < 3) ? 32'h011 : 32'h044;
      req_rd  = (c < 3) ? 5'd7 : 5'd9;
      fpu_result = (c == 1) ? 32'h111 : (c == 4) ? 32'h344 : $urandom;
      #1;
      if (req_valid && req_ready) acc.push_back(c);
      if (wb_valid) begin
        wbc.push_back(c);
        chk("b2b_data", wb_data, (c < 4) ? 32'h111 : 32'h344);
        chk("b2b_rd", 32'(wb_rd), (c < 4) ? 32'd7 : 32'd9);
      end
    end
    chk("b2b_accepts", 32'(acc.size()), 32'd2);
    chk("b2b_pulses", 32'(wbc.size()), 32'd2);
    if (acc.size() == 2) chk("b2b_gap", 32'(acc[1] - acc[0]), 32'd3);
    if (wbc.size() == 2) begin
      chk("b2b_wb0", 32'(wbc[0]), 32'd2);
      chk("b2b_wb1", 32'(wbc[1]), 32'd5);
    end

    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SQRT; req_rs1 = 32'h1000;
    req_rs2 = '0; req_rd = 5'd3; fpu_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("rst_sqrt_exec", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset_wb_rd", 32'(wb_rd), 32'd0);
    chk("mid_reset_wb_data", wb_data, '0);
    chk("mid_reset_wb_err", 32'(wb_err), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("after_reset_wbv", 32'(wb_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fpu_issue_controller.md
FPU_ISSUE_CONTROLLER -- requirements
Module: fpu_issue_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data path width.
REQ-002 The block SHALL have parameter FBITS, default 10, giving the fractional bits; it is documentation only and does not alter datapath logic.
REQ-003 The block SHALL have parameter GUARD, default 2, giving the cycles fpu_ready is ignored after a MUL/SQRT issue.
REQ-004 The block SHALL have parameter TIMEOUT, default 63, giving the maximum EXEC cycles before an error completion.
REQ-005 The block SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have req_valid, input, 1 bit: decode presents an FPU instruction.
REQ-008 The block SHALL have req_ready, output, 1 bit: the controller accepts this cycle.
REQ-009 The block SHALL have req_op, input, 2 bits: an operation code using the shared FPU_ADD/FPU_SUB/FPU_MUL/FPU_SQRT defines.
REQ-010 The block SHALL have req_rs1 and req_rs2, inputs, WIDTH bits each: the operands (rs2 is unused for SQRT).
REQ-011 The block SHALL have req_rd, input, 5 bits: the destination register index.
REQ-012 The block SHALL have flush, input, 1 bit: aborts any in-flight operation.
REQ-013 The block SHALL have fpu_operand_1, fpu_operand_2 and fpu_operation, outputs of WIDTH, WIDTH and 2 bits, driving the fixed-point unit.
REQ-014 The block SHALL have fpu_result, input, WIDTH bits, and fpu_ready, input, 1 bit, returned by the fixed-point unit.
REQ-015 The block SHALL have wb_valid, output, 1 bit: a one-cycle writeback pulse.
REQ-016 The block SHALL have wb_rd (5 bits), wb_data (WIDTH bits) and wb_err (1 bit) as outputs.
REQ-017 The block SHALL have busy, output, 1 bit: a pipeline stall request, high in every state except IDLE.

Function
REQ-018 The block SHALL implement three states: IDLE, EXEC and WB.
REQ-019 In IDLE, the block SHALL hold req_ready=1; when req_valid=1 and flush=0, it SHALL capture op/rs1/rs2/rd into holding registers, clear cnt and go to EXEC.
REQ-020 In IDLE and WB, the block SHALL drive fpu_operation=FPU_ADD with both operands 0, which keeps the unit's MUL/SQRT sequencers idle.
REQ-021 In EXEC, the block SHALL drive the captured op and operands, stable every cycle, and increment cnt (6 bits, saturating) each cycle.
REQ-022 For ADD/SUB in EXEC, the block SHALL complete in the first EXEC cycle (cnt==0), capturing fpu_result regardless of fpu_ready.
REQ-023 For MUL/SQRT in EXEC, the block SHALL complete in the first cycle with cnt>=GUARD and fpu_ready=1, capturing fpu_result; this masks stale ready left from a prior operation.
REQ-024 For MUL/SQRT, if cnt==TIMEOUT is reached without completion, the block SHALL go to WB with wb_err=1 and wb_data=0.
REQ-025 On completion, the block SHALL go to WB.
REQ-026 In WB, the block SHALL assert wb_valid=1 for exactly one cycle with wb_rd and the latched wb_data/wb_err, then return to IDLE.
REQ-027 req_ready SHALL be 0 in EXEC and WB.
REQ-028 Latency SHALL be as follows: ADD/SUB accepted at edge t gives wb_valid high in cycle t+2; the next accept is no earlier than t+3.
REQ-029 A MUL accepted at t SHALL give wb_valid no earlier than t+GUARD+2.
REQ-030 Flush in EXEC SHALL return the block to IDLE next cycle with no wb_valid.
REQ-031 Flush in WB SHALL suppress wb_valid and return the block to IDLE.
REQ-032 When flush and req_valid are both high in IDLE, flush SHALL win and nothing is accepted.
REQ-033 wb_data/wb_rd/wb_err SHALL hold their last values outside WB; consumers qualify them with wb_valid only.
REQ-034 The block SHALL apply no arithmetic itself; results SHALL pass through unmodified, with overflow and wrap owned by the unit.

Reset
REQ-035 When reset=0 at a rising edge, the block SHALL set state=IDLE, cnt=0, req_ready=1, busy=0 and wb_valid=0.
REQ-036 On that reset edge, the block SHALL set wb_rd=0, wb_data=0, wb_err=0, fpu_operation=FPU_ADD, fpu_operands=0 and clear the holding registers.
REQ-037 Reset SHALL take priority over flush and req_valid.
REQ-038 Reset mid-EXEC SHALL abandon the operation with no wb_valid.

Verification
REQ-039 The bench SHALL cover ADD: rs1=0x600 (1.5), rs2=0x800 (2.0), rd=5, accepted at t -> wb_valid at t+2, wb_data=0xE00, wb_rd=5, wb_err=0.
REQ-040 The bench SHALL cover MUL: 0x600*0x800 with fpu_ready already high from a prior MUL -> no completion before cnt=GUARD, then wb_data=0xC00 (3.0).
REQ-041 The bench SHALL cover SQRT: rs1=0x1000 (4.0) -> wb_data=0x800 (2.0), with operands and operation stable throughout EXEC.
REQ-042 The bench SHALL cover timeout: MUL with fpu_ready stuck 0 -> wb_valid after TIMEOUT EXEC cycles with wb_err=1 and wb_data=0.
REQ-043 The bench SHALL cover flush: flush=1 at EXEC cycle 3 of a MUL -> IDLE next cycle, no wb_valid, fpu_operation=FPU_ADD.
REQ-044 The bench SHALL cover reset and back-to-back issue: reset=0 mid-SQRT -> all outputs at reset values next cycle; two ADDs with req_valid held -> accepts 3 cycles apart, two distinct wb_valid pulses.
